// File: rtl/mult_unit.sv
// Iterative shift-add 32x32 multiplier with HI/LO registers and mthi/mtlo writes.
// Signed multiplies run on operand magnitudes, and the sign is fixed up in the FIX state.
module mult_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_mult,
    input  logic             mult_sign,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             hi_we,
    input  logic             lo_we,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t             state, next_state;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH:0]     upper_sum;
    logic [CW-1:0]      counter;
    logic               neg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start_mult) next_state = RUN;
            RUN:     if (counter == CW'(WIDTH - 1)) next_state = FIX;
            FIX:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Magnitudes: the most negative value maps onto itself, which is correct as unsigned.
    always_comb begin
        abs_a     = (mult_sign && srca[WIDTH-1]) ? (~srca + 1'b1) : srca;
        abs_b     = (mult_sign && srcb[WIDTH-1]) ? (~srcb + 1'b1) : srcb;
        upper_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (mplier[0] ? mcand : '0)};
        product   = neg ? (~acc + 1'b1) : acc;
    end

    // Shift-right accumulator: add into the upper half, then shift the whole product down a bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            counter <= '0;
            neg     <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (hi_we) hi <= srca;
                    if (lo_we) lo <= srca;
                    if (start_mult) begin
                        mcand   <= abs_a;
                        mplier  <= abs_b;
                        neg     <= mult_sign & (srca[WIDTH-1] ^ srcb[WIDTH-1]);
                        acc     <= '0;
                        counter <= '0;
                    end
                end
                RUN: begin
                    acc     <= {upper_sum, acc[WIDTH-1:1]};
                    mplier  <= mplier >> 1;
                    counter <= counter + 1'b1;
                end
                FIX: begin
                    hi   <= product[2*WIDTH-1:WIDTH];
                    lo   <= product[WIDTH-1:0];
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_mult_unit.sv
// Directed self-checking bench for mult_unit: products, latency, ignored inputs, reset and mthi/mtlo.
module tb_mult_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start_mult = 1'b0;
    logic        mult_sign = 1'b0;
    logic [31:0] srca = '0;
    logic [31:0] srcb = '0;
    logic        hi_we = 1'b0;
    logic        lo_we = 1'b0;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    int checks = 0;
    int failures = 0;
    int done_count = 0;
    int cycles;
    int busy_cycles;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sgn;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs[6];

    mult_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start_mult(start_mult), .mult_sign(mult_sign),
        .srca(srca), .srcb(srcb), .hi_we(hi_we), .lo_we(lo_we),
        .hi(hi), .lo(lo), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done) done_count++;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Drive operands between edges, pass the start edge E0, then drop start_mult.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        srca = a;
        srcb = b;
        mult_sign = sgn;
        start_mult = 1'b1;
        @(posedge clk);
        #1;
        start_mult = 1'b0;
    endtask

    task automatic waitDone(output int n, output int nbusy);
        n = 0;
        nbusy = busy ? 1 : 0;
        while (!done && n < 60) begin
            @(posedge clk);
            #1;
            n++;
            if (busy) nbusy++;
        end
    endtask

    initial begin
        vecs[0] = '{32'd7,        32'd6,        1'b0, 32'h00000000, 32'h0000002A};
        vecs[1] = '{32'hFFFFFFFD, 32'd5,        1'b1, 32'hFFFFFFFF, 32'hFFFFFFF1};
        vecs[2] = '{32'hFFFFFFFD, 32'd5,        1'b0, 32'h00000004, 32'hFFFFFFF1};
        vecs[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 32'h00000001};
        vecs[4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h00000000, 32'h00000001};
        vecs[5] = '{32'h80000000, 32'h80000000, 1'b1, 32'h40000000, 32'h00000000};

        #2;
        checkOutput("reset_hi", hi, 0);
        checkOutput("reset_lo", lo, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            done_count = 0;
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].sgn);
            waitDone(cycles, busy_cycles);
            checkOutput($sformatf("v%0d_latency", i), cycles, 33);
            checkOutput($sformatf("v%0d_busy_cycles", i), busy_cycles, 33);
            checkOutput($sformatf("v%0d_hi", i), hi, vecs[i].exp_hi);
            checkOutput($sformatf("v%0d_lo", i), lo, vecs[i].exp_lo);
            @(posedge clk);
            #1;
            checkOutput($sformatf("v%0d_done_pulses", i), done_count, 1);
            checkOutput($sformatf("v%0d_done_low", i), done, 0);
        end

        // Start and mthi during a multiply are ignored.
        done_count = 0;
        applyStimulus(32'd3, 32'd4, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        srca = 32'd9;
        srcb = 32'd9;
        start_mult = 1'b1;
        hi_we = 1'b1;
        srca = 32'h1234;
        @(posedge clk);
        #1;
        start_mult = 1'b0;
        hi_we = 1'b0;
        checkOutput("ign_hi_held", hi, 32'h40000000);
        waitDone(cycles, busy_cycles);
        checkOutput("ign_latency", cycles, 23);
        checkOutput("ign_hi", hi, 0);
        checkOutput("ign_lo", lo, 12);
        repeat (40) @(posedge clk);
        #1;
        checkOutput("ign_done_pulses", done_count, 1);
        checkOutput("ign_busy_idle", busy, 0);

        // Load nonzero HI/LO, then reset in mid-multiply.
        hi_we = 1'b1;
        lo_we = 1'b1;
        srca = 32'hCAFE0001;
        @(posedge clk);
        #1;
        hi_we = 1'b0;
        lo_we = 1'b0;
        applyStimulus(32'd100, 32'd100, 1'b0);
        repeat (15) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        checkOutput("rst_hi", hi, 0);
        checkOutput("rst_lo", lo, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(32'd2, 32'd2, 1'b0);
        waitDone(cycles, busy_cycles);
        checkOutput("rst_after_latency", cycles, 33);
        checkOutput("rst_after_lo", lo, 4);
        checkOutput("rst_after_hi", hi, 0);
        @(posedge clk);
        #1;

        // mthi then mtlo in IDLE.
        done_count = 0;
        hi_we = 1'b1;
        srca = 32'hDEADBEEF;
        @(posedge clk);
        #1;
        hi_we = 1'b0;
        checkOutput("mthi_hi", hi, 32'hDEADBEEF);
        checkOutput("mthi_lo", lo, 4);
        checkOutput("mthi_busy", busy, 0);
        lo_we = 1'b1;
        srca = 32'h0BADF00D;
        @(posedge clk);
        #1;
        lo_we = 1'b0;
        checkOutput("mtlo_lo", lo, 32'h0BADF00D);
        checkOutput("mtlo_hi", hi, 32'hDEADBEEF);
        checkOutput("mtlo_busy", busy, 0);
        checkOutput("mt_done_pulses", done_count, 0);

        // mthi on the start edge is overwritten by the product.
        hi_we = 1'b1;
        srca = 32'd5;
        srcb = 32'd5;
        mult_sign = 1'b0;
        start_mult = 1'b1;
        @(posedge clk);
        #1;
        hi_we = 1'b0;
        start_mult = 1'b0;
        checkOutput("mt_start_hi", hi, 32'd5);
        checkOutput("mt_start_busy", busy, 1);
        waitDone(cycles, busy_cycles);
        checkOutput("mt_start_latency", cycles, 33);
        checkOutput("mt_start_prod_hi", hi, 0);
        checkOutput("mt_start_prod_lo", lo, 25);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mult_unit.md
Name: mult_unit

Overview:
- Multi-cycle iterative 32x32 integer multiplier with HI/LO result registers, driven by the start_mult/mult_sign controls from the controller.
- Sits beside the execute stage of the pipelined MIPS datapath.
- Takes the forwarded rs/rt operands and produces hi/lo, which feed the out_select result mux (mfhi/mflo).
- Also supports mthi/mtlo writes.

Parameters:
- WIDTH, 32, operand width; product is 2*WIDTH bits; iteration count equals WIDTH.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- start_mult  input  1  begin a multiply; sampled only in IDLE
- mult_sign  input  1  1 = signed (mult), 0 = unsigned (multu); sampled with start_mult
- srca  input  WIDTH  multiplicand (rs)
- srcb  input  WIDTH  multiplier (rt)
- hi_we  input  1  mthi: hi <= srca
- lo_we  input  1  mtlo: lo <= srca
- hi  output  WIDTH  upper product / HI register
- lo  output  WIDTH  lower product / LO register
- busy  output  1  multiply in progress; the pipeline stalls mfhi/mflo/mult while high
- done  output  1  one-cycle pulse when hi/lo take a new product

Behaviour:
- **Reset** (reset==0, asynchronous): state=IDLE; hi=0, lo=0, busy=0, done=0; internal accumulator, counter and sign flag cleared. Any multiply in progress is abandoned, with no partial write to hi/lo.
- **States:** IDLE, RUN, FIX.
- **IDLE**
  - start_mult=1 at a clock edge: capture operands.
    - Signed: capture |srca| and |srcb| as unsigned magnitudes, and neg = srca[MSB]^srcb[MSB].
    - Unsigned: capture the raw operands, neg=0.
  - Clear the 2*WIDTH accumulator, set counter=0, go to RUN.
  - busy goes high in the cycle after the start edge.
- **RUN:** one multiplier bit per cycle, LSB first, shift-add.
  - If the current multiplier bit is 1, add the multiplicand (shifted by counter) into the accumulator, or use an equivalent shift-right accumulator form.
  - counter increments each cycle; after WIDTH RUN cycles go to FIX.
- **FIX** (one cycle):
  - Final product = neg ? two's-complement negate of the 2*WIDTH accumulator : accumulator.
  - At the edge leaving FIX, hi <= product[2W-1:W] and lo <= product[W-1:0]; return to IDLE.
  - done=1 for exactly the following cycle, then busy=0.
- **Latency:** start edge = E0. RUN occupies edges E1..E32; FIX completes at E33. hi/lo are valid and done=1 after E33. busy is high from after E0 until after E33 (33 cycles).
- **Width rules:**
  - abs(0x80000000) = 0x80000000 as unsigned; no overflow case exists.
  - Product is exact to 64 bits for both signed and unsigned.
- **start_mult while busy:** ignored; the operation in flight is unaffected.
- **hi_we/lo_we**
  - In IDLE: write srca at the clock edge. Both may be asserted together.
  - While busy: ignored.
  - Same edge as start_mult in IDLE: the mthi/mtlo write takes effect, and the multiply starts normally. Its result later overwrites hi/lo.
- **Output hold:** hi/lo hold their values between writes. They are not modified during RUN/FIX, so readers see the old values until done.
- **Post-done:** the cycle after done (IDLE) accepts a new start_mult.

Test Plan:
- Unsigned 7 x 6: start_mult=1, mult_sign=0, srca=7, srcb=6 -> busy high for 33 cycles; done pulses once after E33; hi=0x00000000, lo=0x0000002A.
- Signed -3 x 5: srca=0xFFFFFFFD, srcb=5, mult_sign=1 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. Same operands with mult_sign=0 -> hi=0x00000004, lo=0xFFFFFFF1.
- Extremes:
  - Unsigned 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
  - Signed 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0x00000000.
- Ignored inputs while busy:
  - Start 3x4, then at cycle 10 pulse start_mult with 9x9 and assert hi_we with srca=0x1234 -> result hi=0, lo=12. done pulses once only, at the original time.
- Reset mid-operation:
  - Start 100x100, drive reset=0 asynchronously at cycle 15 -> hi=lo=0, busy=0, done=0 immediately.
  - After release, a new 2x2 completes normally: lo=4 after 33 cycles.
- mthi/mtlo in IDLE: hi_we=1, srca=0xDEADBEEF, then lo_we=1, srca=0x0BADF00D -> hi=0xDEADBEEF, lo=0x0BADF00D one edge each; busy and done stay 0.
